pipe_hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage RV32I core (IF, ID, EX, MEM, WB). It watches the instruction in ID, keeps its own shadow of the destination registers in EX/MEM/WB, and drives stall, bubble, flush and operand-forwarding selects for the ID/EX datapath registers. It also keeps saturating performance counters of stall and flush cycles. It sits beside the decode stage and is the only source of pipeline-control signals.

---
 rtl/pipe_hazard_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard detection, stall/bubble/flush generation and
// operand-forward selection for the 5-stage RV32I pipeline (IF ID EX MEM WB).
// Keeps a private shadow of {rd, we, load} for EX, MEM and WB, plus saturating
// stall/flush cycle counters.
// Build option: define HAZARD_FWD_EN to enable operand forwarding; when it is
// undefined every RAW dependency interlocks until the producer has retired.
module pipe_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_we,
    input  logic             id_load,
    input  logic             ex_branch_taken,
    output logic             stall,
    output logic             bubble_ex,
    output logic             flush_ifid,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        S_RUN,
        S_INTERLOCK,
        S_FLUSH
    } state_t;

    typedef struct packed {
        logic [4:0] rd;
        logic       we;
        logic       load;
    } shadow_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t  state_q, state_d;
    shadow_t ex_q, mem_q, wb_q;
    shadow_t ex_d;

    logic [1:0]       fwd_a_q, fwd_b_q;
    logic [1:0]       fwd_a_d, fwd_b_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    logic id_live;
    logic m_ex_a, m_mem_a, m_wb_a;
    logic m_ex_b, m_mem_b, m_wb_b;
    logic raw_hazard;

    // The WB load flag has no consumer: it is kept only so every shadow
    // stage carries the same record.
    logic unused_shadow_bits;
    assign unused_shadow_bits = wb_q.load;

    // A shadow stage matches a source when it writes a non-zero rd equal to
    // that source and the ID instruction really reads it.
    function automatic logic src_match(input shadow_t s, input logic [4:0] src,
                                       input logic use_src);
        return s.we && (s.rd != 5'd0) && (s.rd == src) && use_src;
    endfunction

    // Source match flags and the raw-hazard condition for the current ID slot.
    always_comb begin
        // In the cycle after a taken branch the ID slot holds a squashed
        // instruction, so whatever id_valid says is ignored.
        id_live = id_valid && (state_q != S_FLUSH);

        m_ex_a  = src_match(ex_q,  id_rs1, id_use_rs1);
        m_mem_a = src_match(mem_q, id_rs1, id_use_rs1);
        m_wb_a  = src_match(wb_q,  id_rs1, id_use_rs1);
        m_ex_b  = src_match(ex_q,  id_rs2, id_use_rs2);
        m_mem_b = src_match(mem_q, id_rs2, id_use_rs2);
        m_wb_b  = src_match(wb_q,  id_rs2, id_use_rs2);

`ifdef HAZARD_FWD_EN
        // Only a load in EX cannot be forwarded in time.
        raw_hazard = id_live && ex_q.load && (m_ex_a || m_ex_b);
`else
        // Without forwarding any in-flight producer blocks the reader.
        raw_hazard = id_live &&
                     (m_ex_a || m_mem_a || m_wb_a || m_ex_b || m_mem_b || m_wb_b);
`endif
    end

    // Pipeline control outputs; a taken branch overrides any stall.
    always_comb begin
        stall      = 1'b0;
        bubble_ex  = 1'b0;
        flush_ifid = 1'b0;
        if (!reset) begin
            if (ex_branch_taken) begin
                flush_ifid = 1'b1;
                bubble_ex  = 1'b1;
            end else if (state_q == S_FLUSH) begin
                bubble_ex  = 1'b1;
            end else if (raw_hazard) begin
                stall      = 1'b1;
                bubble_ex  = 1'b1;
            end
        end
    end

    // Next FSM state.
    always_comb begin
        state_d = state_q;
        if (ex_branch_taken) begin
            state_d = S_FLUSH;
        end else if (state_q == S_FLUSH) begin
            state_d = S_RUN;
        end else if (raw_hazard) begin
            state_d = S_INTERLOCK;
        end else begin
            state_d = S_RUN;
        end
    end

    // Next EX shadow entry and forward selects for the instruction entering EX.
    always_comb begin
        ex_d    = '0;
        fwd_a_d = 2'b00;
        fwd_b_d = 2'b00;
        if (id_live && !bubble_ex) begin
            ex_d.rd   = id_rd;
            ex_d.we   = id_we;
            ex_d.load = id_load;
`ifdef HAZARD_FWD_EN
            // Youngest producer wins: EX, then MEM, then WB.
            if (m_ex_a)       fwd_a_d = 2'b01;
            else if (m_mem_a) fwd_a_d = 2'b10;
            else if (m_wb_a)  fwd_a_d = 2'b11;
            if (m_ex_b)       fwd_b_d = 2'b01;
            else if (m_mem_b) fwd_b_d = 2'b10;
            else if (m_wb_b)  fwd_b_d = 2'b11;
`endif
        end
    end

    // State, shadow pipeline and forward-select registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RUN;
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            fwd_a_q <= 2'b00;
            fwd_b_q <= 2'b00;
        end else begin
            state_q <= state_d;
            ex_q    <= ex_d;
            mem_q   <= ex_q;
            wb_q    <= mem_q;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    // Saturating stall/flush cycle counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_ONE;
            end
            if (flush_ifid && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_ONE;
            end
        end
    end

    assign fwd_a     = fwd_a_q;
    assign fwd_b     = fwd_b_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl. A stimulus process drives the ID slot
// and pushes the expected response of each cycle; a monitor on the falling edge
// pops and compares. The reference keeps the last three instructions that
// entered EX and reasons about producer distance.
module tb_pipe_hazard_ctrl;

`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam int CW   = 8;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          id_valid;
    logic [4:0]    id_rs1, id_rs2, id_rd;
    logic          id_use_rs1, id_use_rs2, id_we, id_load;
    logic          ex_branch_taken;
    logic          stall, bubble_ex, flush_ifid;
    logic [1:0]    fwd_a, fwd_b;
    logic [CW-1:0] stall_cnt, flush_cnt;

    pipe_hazard_ctrl #(.CNT_W(CW)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .id_rd           (id_rd),
        .id_we           (id_we),
        .id_load         (id_load),
        .ex_branch_taken (ex_branch_taken),
        .stall           (stall),
        .bubble_ex       (bubble_ex),
        .flush_ifid      (flush_ifid),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rd;
        bit we;
        bit ld;
    } prod_t;

    typedef struct {
        int st, bub, fl, fa, fb, sc, fc;
    } exp_t;

    exp_t  sb[$];
    int    total = 0;
    int    bad   = 0;

    // reference state: hist[d] = instruction that entered EX d cycles ago
    prod_t hist [1:3];
    int    m_fa, m_fb, m_sc, m_fc;
    bit    m_flush_pend;
    bit    last_stall;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // distance (1..3) to the youngest in-flight writer of src, 0 if none
    function automatic int youngest(input logic [4:0] src, input bit use_s);
        if (!use_s || src == 5'd0) return 0;
        for (int d = 1; d <= 3; d++) begin
            if (hist[d].we && hist[d].rd == int'(src)) return d;
        end
        return 0;
    endfunction

    task automatic model_clear();
        for (int d = 1; d <= 3; d++) hist[d] = '{0, 1'b0, 1'b0};
        m_fa = 0; m_fb = 0; m_sc = 0; m_fc = 0;
        m_flush_pend = 1'b0;
    endtask

    // drive one cycle, push its expected response, advance the reference
    task automatic step(input bit rst, input bit v,
                        input logic [4:0] rs1, input bit u1,
                        input logic [4:0] rs2, input bit u2,
                        input logic [4:0] rd, input bit we, input bit ld,
                        input bit br);
        exp_t e;
        int   d1, d2;
        bit   live, hz;
        reset = rst; id_valid = v;
        id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
        id_rd = rd; id_we = we; id_load = ld; ex_branch_taken = br;

        d1   = youngest(rs1, u1);
        d2   = youngest(rs2, u2);
        live = v && !m_flush_pend;
        if (FWD) hz = live && hist[1].ld && (d1 == 1 || d2 == 1);
        else     hz = live && (d1 != 0 || d2 != 0);

        e.st  = int'(!rst && !br && hz);
        e.fl  = int'(!rst && br);
        e.bub = int'(!rst && (br || m_flush_pend || hz));
        e.fa  = m_fa; e.fb = m_fb; e.sc = m_sc; e.fc = m_fc;
        sb.push_back(e);

        if (rst) begin
            model_clear();
        end else begin
            hist[3] = hist[2];
            hist[2] = hist[1];
            if (live && e.bub == 0) begin
                hist[1] = '{int'(rd), we, ld};
                m_fa = FWD ? d1 : 0;
                m_fb = FWD ? d2 : 0;
            end else begin
                hist[1] = '{0, 1'b0, 1'b0};
                m_fa = 0; m_fb = 0;
            end
            if (e.st != 0 && m_sc < MAXC) m_sc++;
            if (e.fl != 0 && m_fc < MAXC) m_fc++;
            m_flush_pend = br;
        end
        last_stall = (e.st != 0);
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        step(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // present an instruction and hold it in ID while it is stalled
    task automatic issue(input logic [4:0] rs1, input bit u1,
                         input logic [4:0] rs2, input bit u2,
                         input logic [4:0] rd, input bit we, input bit ld);
        int n = 0;
        step(1'b0, 1'b1, rs1, u1, rs2, u2, rd, we, ld, 1'b0);
        while (last_stall) begin
            n++;
            if (n > 6) begin
                chk("stall_bound", n, 6);
                break;
            end
            step(1'b0, 1'b1, rs1, u1, rs2, u2, rd, we, ld, 1'b0);
        end
    endtask

    // monitor: compare every presented cycle against the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("stall",      int'(stall),      e.st);
            chk("bubble_ex",  int'(bubble_ex),  e.bub);
            chk("flush_ifid", int'(flush_ifid), e.fl);
            chk("fwd_a",      int'(fwd_a),      e.fa);
            chk("fwd_b",      int'(fwd_b),      e.fb);
            chk("stall_cnt",  int'(stall_cnt),  e.sc);
            chk("flush_cnt",  int'(flush_cnt),  e.fc);
        end
    end

    initial begin
        int w;
        reset = 1'b1; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_we = 1'b0; id_load = 1'b0;
        ex_branch_taken = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;

        // add x5,x1,x2 ; add x6,x5,x3
        nop();
        issue(5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
        issue(5'd5, 1'b1, 5'd3, 1'b1, 5'd6, 1'b1, 1'b0);
        chk("addadd_fwd_a", int'(fwd_a), FWD ? 1 : 0);
        chk("addadd_stalls", int'(stall_cnt), FWD ? 0 : 3);

        // lw x7,0(x0) ; add x8,x7,x1
        do_reset();
        issue(5'd0, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
        issue(5'd7, 1'b1, 5'd1, 1'b1, 5'd8, 1'b1, 1'b0);
        chk("loaduse_fwd_a", int'(fwd_a), FWD ? 2 : 0);
        chk("loaduse_stalls", int'(stall_cnt), FWD ? 1 : 3);

        // producer x9, two independents, consumer at distance 3
        do_reset();
        issue(5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0);
        issue(5'd1, 1'b1, 5'd2, 1'b1, 5'd10, 1'b1, 1'b0);
        issue(5'd1, 1'b1, 5'd2, 1'b1, 5'd11, 1'b1, 1'b0);
        issue(5'd3, 1'b1, 5'd9, 1'b1, 5'd12, 1'b1, 1'b0);
        chk("dist3_fwd_b", int'(fwd_b), FWD ? 3 : 0);
        chk("dist3_stalls", int'(stall_cnt), FWD ? 0 : 1);

        // distance 4: no forwarding, no stall
        do_reset();
        issue(5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) issue(5'd1, 1'b1, 5'd2, 1'b1, 5'd13, 1'b1, 1'b0);
        issue(5'd9, 1'b1, 5'd3, 1'b1, 5'd14, 1'b1, 1'b0);
        chk("dist4_fwd_a", int'(fwd_a), 0);
        chk("dist4_stalls", int'(stall_cnt), 0);

        // write x0 then read x0
        do_reset();
        issue(5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b1);
        issue(5'd0, 1'b1, 5'd0, 1'b1, 5'd15, 1'b1, 1'b0);
        chk("x0_fwd_a", int'(fwd_a), 0);
        chk("x0_stalls", int'(stall_cnt), 0);

        // taken branch coincident with load-use: flush only
        do_reset();
        issue(5'd0, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
        step(1'b0, 1'b1, 5'd7, 1'b1, 5'd1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 5'd7, 1'b1, 5'd1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
        chk("br_flush_cnt", int'(flush_cnt), 1);
        chk("br_stall_cnt", int'(stall_cnt), 0);

        // reset in the middle of a load-use stall
        issue(5'd0, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
        step(1'b0, 1'b1, 5'd7, 1'b1, 5'd1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 5'd7, 1'b1, 5'd1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
        nop();
        chk("rst_stall_cnt", int'(stall_cnt), 0);
        chk("rst_flush_cnt", int'(flush_cnt), 0);

        // 2^CW+5 stalls: counter must stick at all-ones
        for (int i = 0; i < MAXC + 6; i++) begin
            step(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b1, 1'b0);
            step(1'b0, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0);
        end
        chk("sat_stall_cnt", int'(stall_cnt), MAXC);

        // randomized traffic, occasional branches and resets
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 2,
                 $urandom_range(0, 9) < 8,
                 5'($urandom_range(0, 7)), 1'($urandom),
                 5'($urandom_range(0, 7)), 1'($urandom),
                 5'($urandom_range(0, 7)), 1'($urandom), $urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) == 0);
        end

        w = 0;
        while (sb.size() > 0 && w < 10) begin
            @(posedge clk);
            w++;
        end
        if (sb.size() > 0) chk("scoreboard_drain", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
